// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and op classification for seq_alu.
// SEQ_ALU_DIV_EN selects whether DIVU/REMU run on the iterative unit.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_MULH = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL) || (op == OP_MULH);
`endif
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shift-add multiplier and restoring divider, one bit per cycle.
// Accumulator holds {hi, lo}: product, or {remainder, quotient}.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hi_sel,
  input  logic             div_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] mul_nx;
  logic [WIDTH-1:0]   m;
  logic [WIDTH:0]     msum;
  logic [CW-1:0]      cnt;
  logic               busy;
  logic               hi_q;

  assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                  (acc[0] ? {1'b0, m} : '0);
  assign mul_nx = {msum, acc[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   rsh;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] div_nx;

  // Negative trial difference restores the shifted remainder
  assign rsh    = acc[2*WIDTH-1:WIDTH-1];
  assign diff   = rsh - {1'b0, m};
  assign div_nx = diff[WIDTH]
                ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign acc_nx = div_q ? div_nx : mul_nx;
`else
  logic unused_div;
  assign unused_div = div_sel;
  assign acc_nx     = mul_nx;
`endif

  assign done = busy && (cnt == '0);
  assign res  = hi_q ? acc_nx[2*WIDTH-1:WIDTH]
                     : acc_nx[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      m    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      hi_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      cnt  <= CW'(WIDTH-1);
      busy <= 1'b1;
      hi_q <= hi_sel;
`ifdef SEQ_ALU_DIV_EN
      div_q <= div_sel;
      acc   <= {{WIDTH{1'b0}}, div_sel ? a : b};
      m     <= div_sel ? b : a;
`else
      acc   <= {{WIDTH{1'b0}}, b};
      m     <= a;
`endif
    end else if (busy) begin
      acc <= acc_nx;
      cnt <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU behind valid/ready; MUL/MULH iterate WIDTH cycles.
// Define SEQ_ALU_DIV_EN to build the DIVU/REMU divider.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       aluoperation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic             gt
);

  state_t           st;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] iter_y;
  logic             accept;
  logic             multi;
  logic             done;
  logic             c_lt;
  logic             c_gt;

  assign in_ready  = (st == ST_IDLE);
  assign out_valid = (st == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign multi     = is_multicycle(aluoperation);

  // Flags see live inputs on accept, latched operands after CALC
  assign opa = in_ready ? data1 : a_q;
  assign opb = in_ready ? data2 : b_q;

  always_comb begin
    if (SIGNED_CMP) begin
      c_lt = $signed(opa) < $signed(opb);
      c_gt = $signed(opa) > $signed(opb);
    end else begin
      c_lt = opa < opb;
      c_gt = opa > opb;
    end
  end

  always_comb begin
    alu_y = data1 + data2;
    unique case (1'b1)
      aluoperation == OP_AND: alu_y = data1 & data2;
      aluoperation == OP_OR:  alu_y = data1 | data2;
      aluoperation == OP_SUB: alu_y = data1 - data2;
      aluoperation == OP_XOR: alu_y = data1 ^ data2;
      aluoperation == OP_SLT: alu_y = {{(WIDTH-1){1'b0}}, c_lt};
      default: ;
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && multi),
    .hi_sel  (aluoperation[0]),
    .div_sel (aluoperation[1]),
    .a       (data1),
    .b       (data2),
    .done    (done),
    .res     (iter_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      zero   <= 1'b0;
      lt     <= 1'b0;
      gt     <= 1'b0;
    end else begin
      unique case (st)
        ST_IDLE: if (accept) begin
          a_q <= data1;
          b_q <= data2;
          if (multi) begin
            st <= ST_CALC;
          end else begin
            st     <= ST_DONE;
            result <= alu_y;
            zero   <= (alu_y == '0);
            lt     <= c_lt;
            gt     <= c_gt;
          end
        end
        ST_CALC: if (done) begin
          st     <= ST_DONE;
          result <= iter_y;
          zero   <= (iter_y == '0);
          lt     <= c_lt;
          gt     <= c_gt;
        end
        ST_DONE: if (out_ready) st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised bench for seq_alu: unsigned and signed-compare instances
// driven in lockstep and checked against an arithmetic reference.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic [3:0]  aluop = '0;

  logic        ir0, ir1, ov0, ov1;
  logic [31:0] r0, r1;
  logic        z0, z1, l0, l1, g0, g1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32), .SIGNED_CMP(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .data1(data1), .data2(data2), .aluoperation(aluop),
    .out_valid(ov0), .out_ready(out_ready), .result(r0),
    .zero(z0), .lt(l0), .gt(g0)
  );

  seq_alu #(.WIDTH(32), .SIGNED_CMP(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .data1(data1), .data2(data2), .aluoperation(aluop),
    .out_valid(ov1), .out_ready(out_ready), .result(r1),
    .zero(z1), .lt(l1), .gt(g1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_lt(input logic [31:0] a, b, input bit sg);
    return sg ? ($signed(a) < $signed(b)) : (a < b);
  endfunction

  function automatic bit ref_gt(input logic [31:0] a, b, input bit sg);
    return sg ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  function automatic bit ref_multi(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return op >= 4'd8 && op <= 4'd11;
`else
    return op == 4'd8 || op == 4'd9;
`endif
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] op,
                                          input logic [31:0] a, b,
                                          input bit sg);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd3: return a - b;
      4'd4: return a ^ b;
      4'd7: return ref_lt(a, b, sg) ? 32'd1 : 32'd0;
      4'd8: return p[31:0];
      4'd9: return p[63:32];
`ifdef SEQ_ALU_DIV_EN
      4'd10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11: return (b == 0) ? a : a % b;
`endif
      default: return a + b;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, b,
                        input int hold, input bit noise);
    int lat, want, bad;
    logic [31:0] e0, e1;
    e0 = ref_res(op, a, b, 1'b0);
    e1 = ref_res(op, a, b, 1'b1);
    want = ref_multi(op) ? 33 : 1;
    chk("in_ready_idle", ir0, 1'b1);
    in_valid = 1'b1; data1 = a; data2 = b; aluop = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!ov0 && lat < 200) begin
      if (noise && lat >= 2 && lat <= 10) begin
        in_valid = 1'b1;
        data1 = $urandom; data2 = $urandom;
        aluop = 4'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk($sformatf("latency op%0d", op), lat, want);
    chk("valid1", ov1, 1'b1);
    chk($sformatf("res0 op%0d", op), r0, e0);
    chk($sformatf("res1 op%0d", op), r1, e1);
    chk("zero0", z0, e0 == 0);
    chk("zero1", z1, e1 == 0);
    chk("lt0", l0, ref_lt(a, b, 1'b0));
    chk("gt0", g0, ref_gt(a, b, 1'b0));
    chk("lt1", l1, ref_lt(a, b, 1'b1));
    chk("gt1", g1, ref_gt(a, b, 1'b1));
    chk("in_ready_done", ir0, 1'b0);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (r0 !== e0 || !ov0 || ir0 || r1 !== e1) bad++;
    end
    if (hold > 0) chk("hold_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drop_valid", ov0, 1'b0);
    chk("back_idle", ir0, 1'b1);
  endtask

  initial begin
    #12;
    chk("rst_result", r0, 0);
    chk("rst_flags", {z0, l0, g0, ov0}, 4'b0);
    chk("rst_in_ready", ir0, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'd2, 32'd1, 32'd2, 0, 0);
    run_op(4'd3, 32'd1, 32'd2, 0, 0);
    run_op(4'd8, 32'h0001_0000, 32'h0001_0000, 0, 0);
    run_op(4'd9, 32'h0001_0000, 32'h0001_0000, 0, 0);
    run_op(4'd10, 32'd100, 32'd7, 0, 0);
    run_op(4'd11, 32'd100, 32'd7, 0, 0);
    run_op(4'd10, 32'd5, 32'd0, 0, 0);
    run_op(4'd11, 32'd5, 32'd0, 0, 0);
    run_op(4'd3, 32'd9, 32'd9, 0, 0);
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run_op(4'd8, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1);
    run_op(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 10, 1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("stray_ready", ov0, 1'b0);
    out_ready = 1'b0;

    // abort a divide mid-flight
    in_valid = 1'b1; data1 = 32'd1000; data2 = 32'd3; aluop = 4'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_result", {r0, r1}, 64'd0);
    chk("abort_flags", {z0, l0, g0, ov0, z1, l1, g1, ov1}, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov0 || ov1) begin
        chk("stale_valid", 1'b1, 1'b0);
        break;
      end
    end
    run_op(4'd2, 32'd4, 32'd4, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      int mode;
      a = $urandom; b = $urandom;
      mode = $urandom_range(0, 3);
      if (mode == 1) b = a;
      if (mode == 2) b = 0;
      if (mode == 3) begin
        a = $urandom_range(0, 300);
        b = $urandom_range(0, 20);
      end
      run_op(4'($urandom_range(0, 15)), a, b,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
